wavetable_voice_mixer: RTL and testbench
========================================

// Module: wavetable_voice_mixer
// PURPOSE
// Consumer side of the per-note wavetable address bus. On each audio sample tick it snapshots
// the per-note addresses and the active-voice mask, then reads one shared single-port
// wavetable BRAM per note, time-multiplexed. It sums the samples of the active notes and emits
// one signed mixed sample with a valid pulse. Sits between the address generator and the DAC/PWM output stage.
// PARAMETERS
// ADDR_WIDTH    8   wavetable address width; matches generator address width
// NUM_NOTES     24  number of note lanes
// SAMPLE_WIDTH  8   BRAM sample width, signed two's complement
// BRAM_LATENCY  2   cycles from bram_addr_out to valid bram_data_in (>=1)
// OUT_WIDTH     16  mix_out width; must be >= ACC_W = SAMPLE_WIDTH+5
// PORTS
// clk_in           in   1                        system clock
// rst_n_in         in   1                        reset, asynchronous, active-low
// sample_tick_in   in   1                        1-cycle pulse: start a mixing frame
// addr_in          in   [ADDR_WIDTH-1:0] x NUM_NOTES  per-note wavetable address
// active_voices_in in   NUM_NOTES                per-note gate/active mask
// bram_addr_out    out  ADDR_WIDTH               wavetable BRAM read address
// bram_data_in     in   SAMPLE_WIDTH             wavetable BRAM read data (signed)
// mix_out          out  OUT_WIDTH                mixed sample (signed), held between frames
// mix_valid_out    out  1                        1-cycle pulse when mix_out updates
// voice_count_out  out  5                        active notes counted in last frame
// busy_out         out  1                        frame in progress
// overrun_out      out  1                        1-cycle pulse: tick arrived while busy
// BEHAVIOUR
// - Reset: clk_in, async active-low rst_n_in. All outputs 0; FSM=IDLE; accumulator, snapshot
//   and pipeline valid/mask shift registers cleared. Assertion mid-frame aborts the frame;
//   no mix_valid_out follows.
// - FSM: IDLE -> FETCH -> DRAIN -> (DIVIDE) -> DONE -> IDLE.
// - IDLE: tick at cycle T latches addr_in/active_voices_in, clears accumulator and count.
//   Sets busy_out from T+1.
// - FETCH: cycles T+1..T+NUM_NOTES drive bram_addr_out = snapshot addr[k], k = 0..NUM_NOTES-1.
//   All lanes are fetched; the active bit for lane k travels in a BRAM_LATENCY-deep shift register.
// - Data for lane k is accumulated BRAM_LATENCY cycles after its address, only if its active bit is set.
//   Signed add at ACC_W bits cannot overflow for NUM_NOTES<=32. The count increments likewise.
// - DRAIN: BRAM_LATENCY cycles. bram_addr_out returns to 0 outside FETCH.
// - DONE: mix_out = sign-extended result, voice_count_out = count, mix_valid_out=1, busy_out=0 next.
//   Latency, macro off: mix_valid_out at T+NUM_NOTES+BRAM_LATENCY+1 (T+27 at defaults).
// - No active notes: full frame still runs; mix_out=0, count=0, valid pulses.
// - Tick while busy: ignored; overrun_out pulses the same cycle; frame continues unchanged.
//   Tick in the DONE cycle is also an overrun.
// - Inputs changing mid-frame have no effect; the snapshot is used.
// CONFIGURATION
// - MIXER_NORMALIZE_EN defined: adds DIVIDE state, a sequential restoring divider.
//   mix_out = accumulator / count, truncated toward zero. Computed on magnitude with sign restored.
//   ACC_W extra cycles; valid at T+NUM_NOTES+BRAM_LATENCY+1+ACC_W (T+40 at defaults).
//   count==0 gives 0.
// - MIXER_NORMALIZE_EN undefined: no divider logic; raw sum as above.
// TESTING
// 1 Reset: hold rst_n_in=0 mid-FETCH -> all outputs 0 immediately; no valid pulse afterwards.
// 2 Active mask 0x000001, BRAM[addr]=+5 -> valid at T+27, mix_out=5, voice_count_out=1.
// 3 All 24 active, BRAM=-128 everywhere -> mix_out=-3072 (macro off); -128 (macro on, T+40).
// 4 Mask 0x000000 -> valid pulse, mix_out=0, count=0; bram_addr_out sequence still 24 cycles.
// 5 Second tick at T+5 -> overrun_out=1 at T+5, exactly one valid pulse, result of first snapshot.
// 6 3 active with +7,+7,-4 and macro on -> mix_out=3 (10/3 truncated); macro off -> 10.

Source files
------------

// File: rtl/wavetable_voice_mixer_if.sv
// Bundle of the mixer's address-bus, BRAM and mix-output signals.
// The mixer connects through the slave modport; the driving side uses the master modport.
interface wavetable_voice_mixer_if #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned NUM_NOTES    = 24,
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned OUT_WIDTH    = 16
);
  logic                                  sample_tick_in;
  logic [NUM_NOTES-1:0][ADDR_WIDTH-1:0]  addr_in;
  logic [NUM_NOTES-1:0]                  active_voices_in;
  logic [ADDR_WIDTH-1:0]                 bram_addr_out;
  logic signed [SAMPLE_WIDTH-1:0]        bram_data_in;
  logic signed [OUT_WIDTH-1:0]           mix_out;
  logic                                  mix_valid_out;
  logic [4:0]                            voice_count_out;
  logic                                  busy_out;
  logic                                  overrun_out;

  modport slave (
    input  sample_tick_in, addr_in, active_voices_in, bram_data_in,
    output bram_addr_out, mix_out, mix_valid_out, voice_count_out, busy_out, overrun_out
  );

  modport master (
    output sample_tick_in, addr_in, active_voices_in, bram_data_in,
    input  bram_addr_out, mix_out, mix_valid_out, voice_count_out, busy_out, overrun_out
  );
endinterface

// File: rtl/wavetable_voice_mixer.sv
// Per-tick mixer: snapshots note addresses/mask, fetches each lane from one shared BRAM and sums
// the active lanes. Define MIXER_NORMALIZE_EN to divide the sum by the active-voice count.
module wavetable_voice_mixer #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned NUM_NOTES    = 24,
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned BRAM_LATENCY = 2,
  parameter int unsigned OUT_WIDTH    = 16
) (
  input logic                  clk_in,
  input logic                  rst_n_in,
  wavetable_voice_mixer_if.slave bus
);
  localparam int unsigned ACC_W = SAMPLE_WIDTH + 5;
  localparam int unsigned CNT_W = $clog2(NUM_NOTES + ACC_W + BRAM_LATENCY + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StDivide, StDone} state_e;

  state_e                               r_state;
  logic [CNT_W-1:0]                     r_idx;
  logic [NUM_NOTES-1:0][ADDR_WIDTH-1:0] r_snap_addr;
  logic [NUM_NOTES-1:0]                 r_snap_act;
  logic [BRAM_LATENCY-1:0]              r_pipe;
  logic signed [ACC_W-1:0]              r_acc;
  logic [4:0]                           r_cnt;
  logic [ADDR_WIDTH-1:0]                r_bram_addr;
  logic signed [OUT_WIDTH-1:0]          r_mix;
  logic                                 r_valid;
  logic [4:0]                           r_vcount;
  logic                                 r_busy;

  logic                                 w_shift_in;
  logic signed [ACC_W-1:0]              w_data_ext;
  logic signed [ACC_W-1:0]              w_acc_nxt;
  logic [4:0]                           w_cnt_nxt;

  assign w_shift_in = (r_state == StFetch) & r_snap_act[0];
  assign w_data_ext = ACC_W'(bus.bram_data_in);
  // The oldest pipeline bit marks the lane whose BRAM data is on bram_data_in this cycle.
  assign w_acc_nxt  = r_pipe[BRAM_LATENCY-1] ? r_acc + w_data_ext : r_acc;
  assign w_cnt_nxt  = r_pipe[BRAM_LATENCY-1] ? r_cnt + 5'd1 : r_cnt;

`ifdef MIXER_NORMALIZE_EN
  logic [ACC_W:0]              r_rem;
  logic [ACC_W-1:0]            r_quo;
  logic                        r_neg;
  logic [ACC_W-1:0]            w_mag;
  logic [ACC_W:0]              w_rem_sh;
  logic [ACC_W:0]              w_div;
  logic                        w_ge;
  logic [ACC_W:0]              w_rem_nxt;
  logic [ACC_W-1:0]            w_quo_nxt;
  logic signed [OUT_WIDTH-1:0] w_q_ext;

  // Restoring division on the magnitude; the sign is reapplied to the quotient.
  assign w_mag     = w_acc_nxt[ACC_W-1] ? -w_acc_nxt : w_acc_nxt;
  assign w_rem_sh  = {r_rem[ACC_W-1:0], r_quo[ACC_W-1]};
  assign w_div     = (ACC_W+1)'(r_cnt);
  assign w_ge      = (w_rem_sh >= w_div);
  assign w_rem_nxt = w_ge ? w_rem_sh - w_div : w_rem_sh;
  assign w_quo_nxt = {r_quo[ACC_W-2:0], w_ge};
  assign w_q_ext   = OUT_WIDTH'(w_quo_nxt);
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_snap_addr <= '0;
      r_snap_act  <= '0;
      r_pipe      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_bram_addr <= '0;
      r_mix       <= '0;
      r_valid     <= 1'b0;
      r_vcount    <= '0;
      r_busy      <= 1'b0;
`ifdef MIXER_NORMALIZE_EN
      r_rem       <= '0;
      r_quo       <= '0;
      r_neg       <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pipe  <= (r_pipe << 1) | BRAM_LATENCY'(w_shift_in);
      case (r_state)
        StIdle: begin
          if (bus.sample_tick_in) begin
            r_bram_addr <= bus.addr_in[0];
            r_snap_addr <= {ADDR_WIDTH'(0), bus.addr_in[NUM_NOTES-1:1]};
            r_snap_act  <= bus.active_voices_in;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_state     <= StFetch;
          end
        end
        StFetch: begin
          r_snap_act  <= r_snap_act >> 1;
          r_snap_addr <= {ADDR_WIDTH'(0), r_snap_addr[NUM_NOTES-1:1]};
          if (r_idx == CNT_W'(NUM_NOTES - 1)) begin
            r_bram_addr <= '0;
            r_idx       <= '0;
            r_state     <= StDrain;
          end else begin
            r_bram_addr <= r_snap_addr[0];
            r_idx       <= r_idx + 1'b1;
          end
        end
        StDrain: begin
          if (r_idx == CNT_W'(BRAM_LATENCY - 1)) begin
            r_idx    <= '0;
`ifdef MIXER_NORMALIZE_EN
            r_rem    <= '0;
            r_quo    <= w_mag;
            r_neg    <= w_acc_nxt[ACC_W-1];
            r_state  <= StDivide;
`else
            r_mix    <= OUT_WIDTH'(w_acc_nxt);
            r_vcount <= w_cnt_nxt;
            r_valid  <= 1'b1;
            r_state  <= StDone;
`endif
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
`ifdef MIXER_NORMALIZE_EN
        StDivide: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_idx == CNT_W'(ACC_W - 1)) begin
            r_idx    <= '0;
            r_mix    <= (r_cnt == 5'd0) ? '0 : (r_neg ? -w_q_ext : w_q_ext);
            r_vcount <= r_cnt;
            r_valid  <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
`endif
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.bram_addr_out   = r_bram_addr;
  assign bus.mix_out         = r_mix;
  assign bus.mix_valid_out   = r_valid;
  assign bus.voice_count_out = r_vcount;
  assign bus.busy_out        = r_busy;
  // Overrun must flag in the same cycle as the offending tick, so it is combinational.
  assign bus.overrun_out     = bus.sample_tick_in & r_busy;
endmodule

// File: tb/tb_wavetable_voice_mixer.sv
// Directed bench for wavetable_voice_mixer with a two-stage BRAM model; follows the
// MIXER_NORMALIZE_EN define for expected results and latency.
module tb_wavetable_voice_mixer;
  localparam int NN = 24;
`ifdef MIXER_NORMALIZE_EN
  localparam int LAT = 40;
`else
  localparam int LAT = 27;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wavetable_voice_mixer_if #(.ADDR_WIDTH(8), .NUM_NOTES(NN), .SAMPLE_WIDTH(8), .OUT_WIDTH(16)) bus ();

  wavetable_voice_mixer #(
    .ADDR_WIDTH(8), .NUM_NOTES(NN), .SAMPLE_WIDTH(8), .BRAM_LATENCY(2), .OUT_WIDTH(16)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  // BRAM with two cycles of read latency.
  logic signed [7:0] mem [256];
  logic signed [7:0] bram_s1;
  always @(posedge clk) begin
    bram_s1          <= mem[bus.bram_addr_out];
    bus.bram_data_in <= bram_s1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    string             nm;
    logic [23:0]       mask;
    logic signed [7:0] v0, v1, v2, vr;
    logic signed [15:0] raw, norm;
    logic [4:0]        cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic load_mem(input logic signed [7:0] v0, v1, v2, vr);
    for (int i = 0; i < 256; i++) mem[i] = vr;
    mem[0] = v0; mem[1] = v1; mem[2] = v2;
    mem[255] = 8'sd50;
  endtask

  // Runs one frame from a tick; tick2_n > 0 adds a second tick in cycle T+tick2_n.
  task automatic run_frame(input string nm, input logic [23:0] mask,
                           input logic signed [15:0] exp_mix, input logic [4:0] exp_cnt,
                           input int tick2_n);
    int valid_n, nvalid, addr_bad;
    logic signed [15:0] got_mix;
    logic [4:0] got_cnt;
    valid_n = -1; nvalid = 0; addr_bad = 0; got_mix = 0; got_cnt = 0;
    @(negedge clk);
    for (int k = 0; k < NN; k++) bus.addr_in[k] = 8'(k);
    bus.active_voices_in = mask;
    bus.sample_tick_in   = 1'b1;
    #1 chk({nm, " overrun_idle"}, bus.overrun_out, 0);
    for (int n = 1; n <= LAT + 4; n++) begin
      @(negedge clk);
      bus.sample_tick_in = 1'b0;
      if (n == 1) chk({nm, " busy_start"}, bus.busy_out, 1);
      if (n <= NN) begin
        if (bus.bram_addr_out != 8'(n - 1)) addr_bad++;
      end else if (bus.bram_addr_out != 8'd0) addr_bad++;
      if (bus.mix_valid_out) begin
        nvalid++;
        if (valid_n < 0) begin
          valid_n = n; got_mix = bus.mix_out; got_cnt = bus.voice_count_out;
        end
      end
      if (n == 2) begin
        for (int k = 0; k < NN; k++) bus.addr_in[k] = 8'hFF;
        bus.active_voices_in = ~mask;
      end
      if (n == tick2_n) begin
        bus.sample_tick_in = 1'b1;
        #1 chk({nm, " overrun"}, bus.overrun_out, 1);
      end
    end
    bus.sample_tick_in = 1'b0;
    chk({nm, " valid_cycle"}, valid_n, LAT);
    chk({nm, " valid_pulses"}, nvalid, 1);
    chk({nm, " mix"}, got_mix, exp_mix);
    chk({nm, " count"}, got_cnt, exp_cnt);
    chk({nm, " addr_seq_errors"}, addr_bad, 0);
    chk({nm, " busy_end"}, bus.busy_out, 0);
    chk({nm, " mix_held"}, bus.mix_out, exp_mix);
  endtask

  initial begin
    logic signed [15:0] e;
    int nvalid;
    rst_n = 1'b0;
    bus.sample_tick_in = 1'b0;
    bus.addr_in = '0;
    bus.active_voices_in = '0;
    load_mem(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst busy", bus.busy_out, 0);
    chk("rst valid", bus.mix_valid_out, 0);
    chk("rst mix", bus.mix_out, 0);
    chk("rst count", bus.voice_count_out, 0);
    chk("rst bram_addr", bus.bram_addr_out, 0);
    chk("rst overrun", bus.overrun_out, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    vecs[0] = '{"single",  24'h000001,  5,   0,  0,    0,     5,    5,  1};
    vecs[1] = '{"all_neg", 24'hFFFFFF, -128, -128, -128, -128, -3072, -128, 24};
    vecs[2] = '{"none",    24'h000000,  9,   9,  9,    9,     0,    0,  0};
    vecs[3] = '{"three",   24'h000007,  7,   7, -4,  100,    10,    3,  3};
    vecs[4] = '{"two_neg", 24'h000006, 20,  -7, -4,   30,   -11,   -5,  2};
    vecs[5] = '{"edges",   24'h800001, 127,  1,  1,  127,   254,  127,  2};
    vecs[6] = '{"all_max", 24'hFFFFFF, 127, 127, 127, 127,  3048,  127, 24};

    for (int i = 0; i < 7; i++) begin
      load_mem(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].vr);
`ifdef MIXER_NORMALIZE_EN
      e = vecs[i].norm;
`else
      e = vecs[i].raw;
`endif
      run_frame(vecs[i].nm, vecs[i].mask, e, vecs[i].cnt, 0);
      repeat (2) @(negedge clk);
    end

    // Tick while fetching, then a tick in the DONE cycle: both ignored.
    load_mem(5, 0, 0, 0);
    run_frame("overrun_fetch", 24'h000001, 16'sd5, 5'd1, 5);
    repeat (2) @(negedge clk);
    load_mem(5, 0, 0, 0);
    run_frame("overrun_done", 24'h000001, 16'sd5, 5'd1, LAT);
    repeat (2) @(negedge clk);

    // Reset asserted mid-FETCH aborts the frame with no later valid pulse.
    load_mem(-128, -128, -128, -128);
    @(negedge clk);
    for (int k = 0; k < NN; k++) bus.addr_in[k] = 8'(k);
    bus.active_voices_in = 24'hFFFFFF;
    bus.sample_tick_in = 1'b1;
    @(negedge clk);
    bus.sample_tick_in = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", bus.busy_out, 0);
    chk("midrst valid", bus.mix_valid_out, 0);
    chk("midrst mix", bus.mix_out, 0);
    chk("midrst count", bus.voice_count_out, 0);
    chk("midrst bram_addr", bus.bram_addr_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int n = 0; n < LAT + 10; n++) begin
      @(negedge clk);
      if (bus.mix_valid_out) nvalid++;
    end
    chk("midrst no_valid_after", nvalid, 0);
    chk("midrst busy_after", bus.busy_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
